// File: rtl/wb_la_bus_arbiter.sv
// Round-robin, single-outstanding arbiter placing the Wishbone slave port (A) and the
// logic-analyzer command port (B) onto one internal request/grant/response bus.
module wb_la_bus_arbiter #(
   parameter int              AW       = 32,
   parameter int              DW       = 32,
   parameter int              TIMEOUT  = 255,
   parameter int              TO_W     = 8,
   parameter logic [DW-1:0]   ERR_WORD = 32'hDEAD_BEEF
) (
   input  logic          wb_clk_i,
   input  logic          wb_rst_i,
   input  logic          wbs_cyc_i,
   input  logic          wbs_stb_i,
   input  logic          wbs_we_i,
   input  logic [3:0]    wbs_sel_i,
   input  logic [AW-1:0] wbs_adr_i,
   input  logic [DW-1:0] wbs_dat_i,
   output logic          wbs_ack_o,
   output logic [DW-1:0] wbs_dat_o,
   input  logic          la_req_i,
   input  logic          la_we_i,
   input  logic [AW-1:0] la_adr_i,
   input  logic [DW-1:0] la_dat_i,
   output logic          la_ack_o,
   output logic [DW-1:0] la_dat_o,
   output logic          la_err_o,
   output logic          m_req_o,
   output logic          m_we_o,
   output logic [3:0]    m_sel_o,
   output logic [AW-1:0] m_adr_o,
   output logic [DW-1:0] m_dat_o,
   input  logic          m_gnt_i,
   input  logic          m_rvalid_i,
   input  logic [DW-1:0] m_rdata_i,
   output logic          timeout_o
);

   typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT, S_DONE} state_e;

   // The abort fires in the cycle the counter would reach TIMEOUT; the counter then
   // saturates so a grant that wins the race cannot trigger a second abort.
   localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT - 1);
   localparam logic [TO_W-1:0] TO_SAT  = TO_W'(TIMEOUT);

   state_e          state_q, state_d;
   logic            grant_b_q, grant_b_d;
   logic            last_b_q, last_b_d;
   logic            err_q, err_d;
   logic [TO_W-1:0] cnt_q, cnt_d, cnt_inc;
   logic            m_req_q, m_req_d;
   logic            m_we_q, m_we_d;
   logic [3:0]      m_sel_q, m_sel_d;
   logic [AW-1:0]   m_adr_q, m_adr_d;
   logic [DW-1:0]   m_dat_q, m_dat_d;
   logic [DW-1:0]   wbs_dat_q, wbs_dat_d;
   logic [DW-1:0]   la_dat_q, la_dat_d;

   logic            req_a, req_b, pick_b, finish, done;
   logic [DW-1:0]   resp;

   assign req_a   = wbs_cyc_i & wbs_stb_i;
   assign req_b   = la_req_i;
   assign cnt_inc = (cnt_q == TO_SAT) ? cnt_q : cnt_q + TO_W'(1);

   always_comb begin
      state_d   = state_q;
      grant_b_d = grant_b_q;
      last_b_d  = last_b_q;
      err_d     = err_q;
      cnt_d     = cnt_q;
      m_req_d   = m_req_q;
      m_we_d    = m_we_q;
      m_sel_d   = m_sel_q;
      m_adr_d   = m_adr_q;
      m_dat_d   = m_dat_q;
      wbs_dat_d = wbs_dat_q;
      la_dat_d  = la_dat_q;
      pick_b    = 1'b0;
      finish    = 1'b0;
      resp      = m_rdata_i;

      case (state_q)
         S_IDLE: begin
            if (req_a || req_b) begin
               // On a tie the side that did not win last time is served.
               pick_b    = req_b && (!req_a || !last_b_q);
               grant_b_d = pick_b;
               last_b_d  = pick_b;
               err_d     = 1'b0;
               cnt_d     = '0;
               m_req_d   = 1'b1;
               state_d   = S_ISSUE;
               if (pick_b) begin
                  m_we_d  = la_we_i;
                  m_sel_d = 4'hF;
                  m_adr_d = la_adr_i;
                  m_dat_d = la_dat_i;
               end else begin
                  m_we_d  = wbs_we_i;
                  m_sel_d = wbs_sel_i;
                  m_adr_d = wbs_adr_i;
                  m_dat_d = wbs_dat_i;
               end
            end
         end
         S_ISSUE: begin
            cnt_d = cnt_inc;
            if (m_gnt_i) begin
               m_req_d = 1'b0;
               state_d = S_WAIT;
            end else if (cnt_q == TO_LAST) begin
               m_req_d = 1'b0;
               err_d   = 1'b1;
               finish  = 1'b1;
               resp    = ERR_WORD;
            end
         end
         S_WAIT: begin
            cnt_d = cnt_inc;
            if (m_rvalid_i) begin
               finish = 1'b1;
               resp   = m_rdata_i;
            end else if (cnt_q == TO_LAST) begin
               err_d  = 1'b1;
               finish = 1'b1;
               resp   = ERR_WORD;
            end
         end
         S_DONE: state_d = S_IDLE;
         default: state_d = S_IDLE;
      endcase

      if (finish) begin
         state_d = S_DONE;
         if (grant_b_q) la_dat_d = resp;
         else wbs_dat_d = resp;
      end
   end

   always_ff @(posedge wb_clk_i) begin
      if (wb_rst_i) begin
         state_q   <= S_IDLE;
         grant_b_q <= 1'b0;
         last_b_q  <= 1'b1;
         err_q     <= 1'b0;
         cnt_q     <= '0;
         m_req_q   <= 1'b0;
         m_we_q    <= 1'b0;
         m_sel_q   <= '0;
         m_adr_q   <= '0;
         m_dat_q   <= '0;
         wbs_dat_q <= '0;
         la_dat_q  <= '0;
      end else begin
         state_q   <= state_d;
         grant_b_q <= grant_b_d;
         last_b_q  <= last_b_d;
         err_q     <= err_d;
         cnt_q     <= cnt_d;
         m_req_q   <= m_req_d;
         m_we_q    <= m_we_d;
         m_sel_q   <= m_sel_d;
         m_adr_q   <= m_adr_d;
         m_dat_q   <= m_dat_d;
         wbs_dat_q <= wbs_dat_d;
         la_dat_q  <= la_dat_d;
      end
   end

   // Acks are gated by the live request so a withdrawn requester sees no ack.
   assign done      = (state_q == S_DONE);
   assign wbs_ack_o = done & ~grant_b_q & req_a;
   assign la_ack_o  = done & grant_b_q & req_b;
   assign timeout_o = done & err_q;
   assign la_err_o  = done & err_q & grant_b_q;
   assign wbs_dat_o = wbs_dat_q;
   assign la_dat_o  = la_dat_q;
   assign m_req_o   = m_req_q;
   assign m_we_o    = m_we_q;
   assign m_sel_o   = m_sel_q;
   assign m_adr_o   = m_adr_q;
   assign m_dat_o   = m_dat_q;

endmodule
